// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the RV32I cores: FSM states, opcodes and
// the select/operation codes driven onto the datapath.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format decode, shared by the multicycle and pipelined cores.
module imm_src_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    // Format lookup; unknown opcodes fall back to the I format.
    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_LW, OP_I: imm_src_o = IMM_I;
            OP_SW:       imm_src_o = IMM_S;
            OP_BEQ:      imm_src_o = IMM_B;
            OP_JAL:      imm_src_o = IMM_J;
            default:     imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control sequencer of the multicycle RV32I core (Moore FSM with
// mem_ready/zero-qualified PC, IR and retire strobes).
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int RESET_STATE_FETCH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal
);

    // The reserved (0) setting has no alternative entry point, so both map to FETCH.
    localparam state_t RESET_STATE = (RESET_STATE_FETCH != 0) ? S_FETCH : S_FETCH;

    state_t state_q, state_d;
    logic   pc_write_s, mem_write_s, ir_write_s, reg_write_s, retire_s;

    imm_src_decoder u_imm_src_decoder (
        .op_i      (op),
        .imm_src_o (imm_src)
    );

    // Next-state selection; op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   state_d = S_ALUWB;
            S_EXEC_I:   state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state datapath controls; everything defaults to zero.
    always_comb begin
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_OP_ADD;
        reg_write_s = 1'b0;
        retire_s    = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
                retire_s    = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_OP_SUB;
                pc_write_s = zero;
                retire_s   = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_write_s = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    // Strobes are blocked while reset is held so an aborted instruction leaves no side effects.
    assign pc_write  = pc_write_s  & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign ir_write  = ir_write_s  & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign retire    = retire_s    & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm: each step pushes the
// expected output vector and pops it when the outputs are sampled mid-cycle.
module tb_multicycle_ctrl_fsm;
    import rv_ctrl_pkg::*;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXEC_R, T_EXEC_I, T_ALUWB, T_BEQ, T_JAL, T_TRAP
    } tstate_e;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = OP_R;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] exp_q[$];
    string       tag_q[$];

    multicycle_ctrl_fsm #(.RESET_STATE_FETCH(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .reg_write(reg_write), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {pc_write, adr_src, mem_write, ir_write,
    // result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, retire, illegal}.
    function automatic logic [16:0] expect_vec(tstate_e st, logic [6:0] o, logic mr, logic z, logic rn);
        logic pcw, adr, mw, irw, rw, ret, ill;
        logic [1:0] rs, sa, sb, aop, imm;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ret = 1'b0; ill = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        case (st)
            T_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            T_MEMREAD:  adr = 1'b1;
            T_MEMWB:    begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
            T_MEMWRITE: begin adr = 1'b1; mw = 1'b1; ret = mr; end
            T_EXEC_R:   begin sa = 2'b10; aop = 2'b10; end
            T_EXEC_I:   begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            T_ALUWB:    begin rw = 1'b1; ret = 1'b1; end
            T_BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = z; ret = 1'b1; end
            T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            T_TRAP:     ill = 1'b1;
            default:    ill = 1'b0;
        endcase
        if (!rn) begin
            pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; ret = 1'b0;
        end
        return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ret, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_op, imm_src, reg_write, retire, illegal};
    endfunction

    task automatic check_now();
        logic [16:0] e;
        string       t;
        logic [16:0] o;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
    endtask

    // One clock of stimulus: drive, push expectation, sample mid-cycle, advance.
    task automatic cyc(tstate_e st, logic [6:0] o, logic mr, logic z, string tag);
        op = o; mem_ready = mr; zero = z;
        exp_q.push_back(expect_vec(st, o, mr, z, 1'b1));
        tag_q.push_back(tag);
        #1;
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        exp_q.push_back(expect_vec(T_FETCH, OP_R, 1'b1, 1'b0, 1'b0));
        tag_q.push_back("reset_hold");
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(T_FETCH,  OP_R, 1'b1, 1'b0, "r_fetch");
        cyc(T_DECODE, OP_R, 1'b1, 1'b0, "r_decode");
        cyc(T_EXEC_R, OP_R, 1'b1, 1'b0, "r_exec");
        cyc(T_ALUWB,  OP_R, 1'b1, 1'b0, "r_aluwb");

        cyc(T_FETCH,   OP_LW, 1'b1, 1'b0, "lw_fetch");
        cyc(T_DECODE,  OP_LW, 1'b1, 1'b0, "lw_decode");
        cyc(T_MEMADR,  OP_LW, 1'b1, 1'b0, "lw_memadr");
        cyc(T_MEMREAD, OP_LW, 1'b0, 1'b0, "lw_memread_w0");
        cyc(T_MEMREAD, OP_LW, 1'b0, 1'b0, "lw_memread_w1");
        cyc(T_MEMREAD, OP_LW, 1'b1, 1'b0, "lw_memread_go");
        cyc(T_MEMWB,   OP_LW, 1'b1, 1'b0, "lw_memwb");

        cyc(T_FETCH,    OP_SW, 1'b1, 1'b0, "sw_fetch");
        cyc(T_DECODE,   OP_SW, 1'b1, 1'b0, "sw_decode");
        cyc(T_MEMADR,   OP_SW, 1'b1, 1'b0, "sw_memadr");
        cyc(T_MEMWRITE, OP_SW, 1'b0, 1'b0, "sw_memwrite_wait");
        cyc(T_MEMWRITE, OP_SW, 1'b1, 1'b0, "sw_memwrite_go");

        cyc(T_FETCH,   OP_I, 1'b0, 1'b0, "i_fetch_wait");
        cyc(T_FETCH,   OP_I, 1'b1, 1'b0, "i_fetch");
        cyc(T_DECODE,  OP_I, 1'b1, 1'b0, "i_decode");
        cyc(T_EXEC_I,  7'h7F, 1'b1, 1'b0, "i_exec_opjunk");
        cyc(T_ALUWB,   OP_BEQ, 1'b1, 1'b0, "i_aluwb_opjunk");

        cyc(T_FETCH,  OP_BEQ, 1'b1, 1'b1, "beq1_fetch");
        cyc(T_DECODE, OP_BEQ, 1'b1, 1'b1, "beq1_decode");
        cyc(T_BEQ,    OP_BEQ, 1'b1, 1'b1, "beq1_taken");
        cyc(T_FETCH,  OP_BEQ, 1'b1, 1'b0, "beq0_fetch");
        cyc(T_DECODE, OP_BEQ, 1'b1, 1'b0, "beq0_decode");
        cyc(T_BEQ,    OP_BEQ, 1'b1, 1'b0, "beq0_not_taken");

        cyc(T_FETCH,  OP_JAL, 1'b1, 1'b0, "jal_fetch");
        cyc(T_DECODE, OP_JAL, 1'b1, 1'b0, "jal_decode");
        cyc(T_JAL,    OP_JAL, 1'b1, 1'b0, "jal_jal");
        cyc(T_ALUWB,  OP_JAL, 1'b1, 1'b0, "jal_aluwb");

        cyc(T_FETCH,  7'h7F, 1'b1, 1'b0, "trap_fetch");
        cyc(T_DECODE, 7'h7F, 1'b1, 1'b0, "trap_decode");
        for (int i = 0; i < 10; i++) begin
            cyc(T_TRAP, (i % 2 == 0) ? OP_R : 7'h7F, 1'b1, i[0], "trap_hold");
        end

        rst_n = 1'b0;
        exp_q.push_back(expect_vec(T_FETCH, 7'h7F, 1'b1, 1'b0, 1'b0));
        tag_q.push_back("trap_async_reset");
        #1;
        check_now();
        #1;
        rst_n = 1'b1;
        cyc(T_FETCH,  OP_R, 1'b1, 1'b0, "post_reset_fetch");
        cyc(T_DECODE, OP_R, 1'b1, 1'b0, "post_reset_decode");
        cyc(T_EXEC_R, OP_R, 1'b1, 1'b0, "post_reset_exec");

        rst_n = 1'b0;
        exp_q.push_back(expect_vec(T_FETCH, OP_R, 1'b1, 1'b0, 1'b0));
        tag_q.push_back("abort_mid_instr");
        #1;
        check_now();
        #1;
        rst_n = 1'b1;
        cyc(T_FETCH, OP_R, 1'b1, 1'b0, "abort_refetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
